// File: rtl/eflags_pkg.sv
// Shared EFLAGS field positions, reserved-bit masks and the write sanitiser.
package eflags_pkg;
  localparam int CF      = 0;
  localparam int PF      = 2;
  localparam int AF      = 4;
  localparam int ZF      = 6;
  localparam int SF      = 7;
  localparam int TF      = 8;
  localparam int IF      = 9;
  localparam int DF      = 10;
  localparam int OF      = 11;
  localparam int IOPL_LO = 12;
  localparam int IOPL_HI = 13;
  localparam int NT      = 14;
  localparam int RF      = 16;
  localparam int VM      = 17;

  localparam logic [31:0] ARITH_MASK = 32'h0000_08D5;
  localparam logic [31:0] RSVD_ONE   = 32'h0000_0002;
  localparam logic [31:0] RSVD_ZERO  = 32'hFFFC_8028;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RESTORE,
    ACT_SAVE,
    ACT_POPF,
    ACT_STATUS
  } eflags_act_e;

  function automatic logic [31:0] sanitise(input logic [31:0] v);
    return (v | RSVD_ONE) & ~RSVD_ZERO;
  endfunction
endpackage

// File: rtl/eflags_save_stack.sv
// Interrupt save LIFO: saturating depth counter, no pointer wrap, error pulses.
module eflags_save_stack #(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_data,
  output logic [31:0]      top_data,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] depth_q;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full     = (depth_q == PTR_W'(DEPTH));
  assign empty    = (depth_q == '0);
  assign depth    = depth_q;
  assign wr_idx   = IDX_W'(depth_q);
  assign rd_idx   = IDX_W'(depth_q - PTR_W'(1));
  assign top_data = mem[rd_idx];

  // Contents need no reset; only depth decides what is valid.
  always_ff @(posedge clock) begin
    if (push && !pop && !full) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && !pop && full;
      underflow <= pop && empty;
      if (pop) begin
        if (!empty) depth_q <= depth_q - PTR_W'(1);
      end else if (push && !full) begin
        depth_q <= depth_q + PTR_W'(1);
      end
    end
  end
endmodule

// File: rtl/eflags_unit.sv
// EFLAGS register: prioritised restore/save/POPF/status updates plus RF retire clear.
module eflags_unit
  import eflags_pkg::*;
#(
  parameter int          SAVE_DEPTH  = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0002,
  localparam int         PTR_W       = $clog2(SAVE_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             status_we,
  input  logic [31:0]      status_mask,
  input  logic [31:0]      status_data,
  input  logic             popf_valid,
  input  logic [31:0]      popf_data,
  input  logic             popf_op32,
  input  logic [1:0]       cpl,
  input  logic             save_req,
  input  logic             save_clear_if,
  input  logic             restore_req,
  input  logic             instr_retire,
  output logic [31:0]      EFLAGS,
  output logic [15:0]      FLAGS,
  output logic [PTR_W-1:0] depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_overflow,
  output logic             stack_underflow,
  output logic             popf_gp
);
  eflags_act_e act;
  logic [31:0] eflags_q, eflags_d, stack_top, popf_wmask, status_m;
  logic [1:0]  iopl;
  logic        gp_d;

  assign EFLAGS   = eflags_q;
  assign FLAGS    = eflags_q[15:0];
  assign iopl     = eflags_q[IOPL_HI:IOPL_LO];
  assign status_m = status_mask & ARITH_MASK;
  assign gp_d     = (act == ACT_POPF) && eflags_q[VM] && (iopl != 2'd3);

  always_comb begin
    act = ACT_NONE;
    if (restore_req)     act = ACT_RESTORE;
    else if (save_req)   act = ACT_SAVE;
    else if (popf_valid) act = ACT_POPF;
    else if (status_we)  act = ACT_STATUS;
  end

  // POPF may only touch the fields the current privilege allows.
  always_comb begin
    popf_wmask          = popf_op32 ? 32'h003F_FFFF : 32'h0000_FFFF;
    popf_wmask[VM]      = 1'b0;
    popf_wmask[RF]      = 1'b0;
    if (cpl != 2'd0) popf_wmask[IOPL_HI:IOPL_LO] = 2'b00;
    if (cpl > iopl)  popf_wmask[IF] = 1'b0;
  end

  always_comb begin
    eflags_d = eflags_q;
    case (act)
      ACT_RESTORE: if (!stack_empty) eflags_d = stack_top;
      ACT_SAVE: if (!stack_full) begin
        eflags_d[TF] = 1'b0;
        eflags_d[NT] = 1'b0;
        eflags_d[RF] = 1'b0;
        if (save_clear_if) eflags_d[IF] = 1'b0;
      end
      ACT_POPF: if (!gp_d) eflags_d = (eflags_q & ~popf_wmask) | (popf_data & popf_wmask);
      ACT_STATUS: eflags_d = (eflags_q & ~status_m) | (status_data & status_m);
      default: ;
    endcase
    if (instr_retire && (act == ACT_NONE || act == ACT_STATUS)) eflags_d[RF] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eflags_q <= sanitise(RESET_VALUE);
      popf_gp  <= 1'b0;
    end else begin
      eflags_q <= sanitise(eflags_d);
      popf_gp  <= gp_d;
    end
  end

  eflags_save_stack #(.DEPTH(SAVE_DEPTH)) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (act == ACT_SAVE),
    .pop       (act == ACT_RESTORE),
    .push_data (eflags_q),
    .top_data  (stack_top),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );
endmodule
